// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multi-cycle RISC core. Every instruction goes
//   through FETCH and DECODE, then a class-specific execute / memory /
//   writeback path. The FSM drives the datapath strobes and produces the
//   3-bit aluop for the downstream ALU control decoder. Memory states stall
//   until mem_ready.
//
//   Optional feature: define MC_CTRL_RETIRE_CNT_EN to build the
//   retired-instruction counter. Without the macro, retired is tied to 0
//   and no counter flops exist.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   opcode[5:0]         instruction[31:26] from IR, stable from DECODE on
//   zero                ALU zero flag (used only in BRANCH)
//   mem_ready           memory finished the current access this cycle
//   mem_read/mem_write  memory strobes; i_or_d selects PC(0) or ALUOut(1)
//   ir_write, pc_we     IR load and PC write enables
//   reg_write, reg_dst, mem_to_reg, alu_src_a, imm_zext   datapath controls
//   alu_src_b[1:0]      00 B, 01 const 4, 10 ext imm, 11 sext imm << 2
//   pc_source[1:0]      00 ALU result, 01 ALUOut, 10 jump target
//   aluop[2:0]          000 add, 001 sub, 010 and, 011 or, 101 slt, 110 R-type
//   illegal             one-cycle pulse in TRAP (undefined opcode)
//   state[3:0]          current state, for debug
//   retired             retired-instruction count
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_we,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic                imm_zext,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [2:0]          aluop,
    output logic                illegal,
    output logic [3:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_LW, C_SW, C_ADDI, C_ANDI, C_ORI, C_SLTI, C_BEQ, C_BNE, C_J, C_ILL
    } op_class_t;

    state_t    cur;
    op_class_t op_class;   // class latched in DECODE
    op_class_t dec_class;  // combinational decode of opcode

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_class = C_ILL;
        case (opcode)
            6'b000000: dec_class = C_R;
            6'b100011: dec_class = C_LW;
            6'b101011: dec_class = C_SW;
            6'b001000: dec_class = C_ADDI;
            6'b001100: dec_class = C_ANDI;
            6'b001101: dec_class = C_ORI;
            6'b001010: dec_class = C_SLTI;
            6'b000100: dec_class = C_BEQ;
            6'b000101: dec_class = C_BNE;
            6'b000010: dec_class = C_J;
            default:   dec_class = C_ILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= S_IDLE;
            op_class <= C_ILL;
        end else begin
            case (cur)
                S_IDLE:   cur <= S_FETCH;
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    op_class <= dec_class;
                    case (dec_class)
                        C_R:                           cur <= S_R_EXEC;
                        C_LW, C_SW:                    cur <= S_MEM_ADDR;
                        C_ADDI, C_ANDI, C_ORI, C_SLTI: cur <= S_I_EXEC;
                        C_BEQ, C_BNE:                  cur <= S_BRANCH;
                        C_J:                           cur <= S_JUMP;
                        default:                       cur <= S_TRAP;
                    endcase
                end
                S_MEM_ADDR:  cur <= (op_class == C_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  if (mem_ready) cur <= S_MEM_WB;
                S_MEM_WB:    cur <= S_FETCH;
                S_MEM_WRITE: if (mem_ready) cur <= S_FETCH;
                S_R_EXEC:    cur <= S_R_WB;
                S_R_WB:      cur <= S_FETCH;
                S_I_EXEC:    cur <= S_I_WB;
                S_I_WB:      cur <= S_FETCH;
                S_BRANCH:    cur <= S_FETCH;
                S_JUMP:      cur <= S_FETCH;
                S_TRAP:      cur <= S_FETCH;
                default:     cur <= S_IDLE;   // unused codes 14-15
            endcase
        end
    end

    // Moore decode of the state register; only FETCH (mem_ready) and
    // BRANCH (zero) look at inputs, so reset clears every output at once.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_we      = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        imm_zext   = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        aluop      = 3'b000;
        illegal    = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;   // branch target into ALUOut
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                aluop     = 3'b110;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_class)
                    C_ANDI: begin aluop = 3'b010; imm_zext = 1'b1; end
                    C_ORI:  begin aluop = 3'b011; imm_zext = 1'b1; end
                    C_SLTI: aluop = 3'b101;
                    default: aluop = 3'b000;   // addi
                endcase
            end
            S_I_WB:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = 3'b001;
                pc_source = 2'b01;
                pc_we     = (op_class == C_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_we     = 1'b1;
            end
            S_TRAP:     illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = cur;

`ifdef MC_CTRL_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] retire_cnt;
    logic                retire_evt;

    // Counts on the edge that leaves the last state of a completed
    // instruction; TRAP deliberately does not retire.
    always_comb begin
        retire_evt = (cur == S_MEM_WB) || (cur == S_R_WB) || (cur == S_I_WB) ||
                     (cur == S_BRANCH) || (cur == S_JUMP) ||
                     ((cur == S_MEM_WRITE) && mem_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retire_cnt <= '0;
        else if (retire_evt)
            retire_cnt <= retire_cnt + RETIRE_W'(1);   // wraps naturally
    end

    assign retired = retire_cnt;
`else
    assign retired = '0;
`endif

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM of the multi-cycle RISC core. It sequences every instruction through fetch, decode, execute, memory and writeback, and drives the datapath strobes. It produces the 3-bit `aluop` consumed by the ALU control decoder, which sits directly downstream. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

## Interface
- `RETIRE_W`, 32, width of the retired-instruction counter.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  instruction[31:26] from IR; stable from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completed the current read/write this cycle.
- `mem_read`, `mem_write`, `i_or_d`, `ir_write`, `pc_we`  out  1 each  datapath strobes (`i_or_d`: 0 = PC address, 1 = ALUOut address).
- `reg_write`, `reg_dst`, `mem_to_reg`, `alu_src_a`, `imm_zext`  out  1 each  register-file, mux and immediate-extension controls.
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = sign-ext imm << 2.
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 R-type (use funct).
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `state`  out  4  current state, for debug.
- `retired`  out  RETIRE_W  retired-instruction count.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12, TRAP=13. Codes 14–15 go to IDLE.
- Outputs are Moore decodes of `state`, except `ir_write`/`pc_we` in FETCH (gated by `mem_ready`) and `pc_we` in BRANCH (gated by `zero`).
- Any output not listed for a state is 0, `aluop` is 000, and the 2-bit selects are 00.
- IDLE: no strobes; next state FETCH.
- FETCH: `mem_read`=1, `alu_src_b`=01, `aluop`=000.
  - If `mem_ready`=1: `ir_write`=1, `pc_we`=1, next DECODE.
  - Otherwise: hold FETCH.
- DECODE: `alu_src_b`=11, `aluop`=000 (branch target into ALUOut). Dispatch on opcode:
  - 000000 → R_EXEC
  - 100011 (lw) / 101011 (sw) → MEM_ADDR
  - 001000 (addi) / 001100 (andi) / 001101 (ori) / 001010 (slti) → I_EXEC
  - 000100 (beq) / 000101 (bne) → BRANCH
  - 000010 (j) → JUMP
  - any other opcode → TRAP
- DECODE also latches the opcode class internally.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `aluop`=000. Next MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Hold until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1; next FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. Hold until `mem_ready`, then FETCH.
- R_EXEC: `alu_src_a`=1, `aluop`=110; next R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1; next FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10, `imm_zext`=1 for andi/ori. `aluop` by opcode: addi 000, andi 010, ori 011, slti 101. Next I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0; next FETCH.
- BRANCH: `alu_src_a`=1, `aluop`=001, `pc_source`=01.
  - beq: `pc_we` = `zero`.
  - bne: `pc_we` = !`zero`.
  - Next FETCH.
- JUMP: `pc_source`=10, `pc_we`=1; next FETCH.
- TRAP: `illegal`=1; next FETCH. PC was already advanced in FETCH, so execution resumes at the next instruction.

## Timing
- Reset is asynchronous and takes effect immediately, including mid-instruction: state=IDLE, every strobe 0, `aluop`=000, `retired`=0, `illegal`=0.
- Minimum cycles per instruction, with `mem_ready` high on its first sampled cycle:
  - lw 5; sw 4; R-type 4; I-type 4; beq/bne 3; j 3; illegal 3.
  - Each additional cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `mem_read`/`mem_write` stay asserted, with stable `i_or_d`, throughout a stall.
- `mem_ready` is ignored in all other states.
- A branch decision uses `zero` sampled in the BRANCH cycle only.

## Configuration
- `MC_CTRL_RETIRE_CNT_EN` defined:
  - `retired` increments by 1 on the clock edge leaving MEM_WB, R_WB, I_WB, BRANCH or JUMP, and on the edge leaving MEM_WRITE with `mem_ready`=1.
  - TRAP does not count.
  - The counter wraps from all-ones to 0.
- Undefined: `retired` is constant 0 and no counter flops are present.

## Test plan
- Reset asserted mid-MEM_READ → same cycle: `state`=0, `mem_read`=0, `retired`=0. After release, IDLE then FETCH.
- lw (100011) with `mem_ready`=1 → states 1,2,3,4,5,1. `reg_write`=`mem_to_reg`=1 in state 5 only; `retired`=1 (macro on).
- FETCH with `mem_ready` low for 3 cycles → `mem_read` high for 4 cycles; single `ir_write`/`pc_we` pulse on the 4th.
- beq, then bne, each with `zero`=1 → `pc_we`=1 for beq and 0 for bne; `aluop`=001 and `pc_source`=01 in BRANCH.
- andi (001100) → I_EXEC with `aluop`=010, `imm_zext`=1. slti (001010) → `aluop`=101, `imm_zext`=0. R-type → `aluop`=110.
- opcode 111111 → TRAP: `illegal` pulses one cycle, then FETCH. `retired` unchanged, and stays 0 throughout with the macro undefined.
